// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one pipelined adder: 1-cycle issue and 1-cycle response, in-order tag FIFO.
// Grants stall only while MAX_OUT ops are in flight without a pop; ADDER_ARB_STATS_EN adds grant counters.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*WIDTH-1:0]   req_y,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_z,
  output logic                       rsp_cout,
  output logic                       add_valid,
  output logic [WIDTH-1:0]           add_x,
  output logic [WIDTH-1:0]           add_y,
  output logic                       add_cin,
  input  logic                       add_ready,
  input  logic [WIDTH-1:0]           add_z,
  input  logic                       add_cout,
`ifdef ADDER_ARB_STATS_EN
  input  logic                       stats_clr,
  output logic [NUM_REQ*16-1:0]      grant_cnt,
`endif
  output logic                       err_orphan
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = AW + 1;

  logic [IW-1:0]      ptr_q, ptr_d, cand;
  logic               any_req, issue_ok, grant, pop;
  logic [IW-1:0]      tag_mem [MAX_OUT];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [IW-1:0]      head;
  logic               add_valid_q, add_cin_q, rsp_cout_q, err_q;
  logic [WIDTH-1:0]   add_x_q, add_y_q, rsp_z_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  // Descending scan so the lowest rotated offset from ptr_q wins.
  always_comb begin
    cand    = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        cand    = IW'((int'(ptr_q) + k) % NUM_REQ);
        any_req = 1'b1;
      end
    end
  end

  assign head      = tag_mem[rd_ptr_q];
  assign pop       = add_ready & (count_q != '0);
  assign issue_ok  = (count_q < CW'(MAX_OUT)) | pop;
  assign grant     = any_req & issue_ok & ~reset;
  assign req_ready = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cand) : '0;
  assign ptr_d     = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;

  always_comb begin
    count_d = count_q;
    if (grant && !pop)      count_d = count_q + 1'b1;
    else if (!grant && pop) count_d = count_q - 1'b1;
  end

  // Tag storage needs no reset: count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr_q] <= cand;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      add_valid_q <= 1'b0;
      add_x_q     <= '0;
      add_y_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      rsp_cout_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      add_valid_q <= grant;
      rsp_valid_q <= pop ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << head) : '0;
      if (grant) begin
        ptr_q     <= ptr_d;
        wr_ptr_q  <= (wr_ptr_q == AW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
        add_x_q   <= req_x[int'(cand)*WIDTH +: WIDTH];
        add_y_q   <= req_y[int'(cand)*WIDTH +: WIDTH];
        add_cin_q <= req_cin[cand];
      end
      if (pop) begin
        rd_ptr_q   <= (rd_ptr_q == AW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
        rsp_z_q    <= add_z;
        rsp_cout_q <= add_cout;
      end
      if (add_ready && count_q == '0) err_q <= 1'b1;
    end
  end

  assign add_valid  = add_valid_q;
  assign add_x      = add_x_q;
  assign add_y      = add_y_q;
  assign add_cin    = add_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_cout   = rsp_cout_q;
  assign err_orphan = err_q;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset || stats_clr)
        cnt_q[i] <= '0;
      else if (grant && cand == IW'(i) && cnt_q[i] != 16'hFFFF)
        cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a fixed-latency behavioural adder.
module tb_adder_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  localparam logic [3:0] FULL_G [17] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                         4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
  localparam logic [3:0] FULL_R [17] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                         4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  localparam logic [7:0] FULL_Z [17] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                         8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
  localparam logic [3:0] ALT_G [4] = '{4'h2, 4'h8, 4'h2, 4'h8};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0, req_ready, req_cin = '0, rsp_valid;
  logic [NUM_REQ*WIDTH-1:0] req_x = '0, req_y = '0;
  logic [WIDTH-1:0]         rsp_z, add_x, add_y, add_z;
  logic                     rsp_cout, add_valid, add_cin, add_ready, add_cout, err_orphan;
`ifdef ADDER_ARB_STATS_EN
  logic                     stats_clr = 1'b0;
  logic [NUM_REQ*16-1:0]    grant_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int lat = 2;
  logic force_rdy = 1'b0;
  logic [15:0] pv;
  logic [WIDTH:0] pz [16];
  logic [3:0] exp_g;

  always #5 clk = ~clk;

  // Behavioural adder: result appears on add_ready exactly lat cycles after add_valid.
  always @(posedge clk) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv    <= {pv[14:0], add_valid};
      pz[0] <= {1'b0, add_x} + {1'b0, add_y} + {8'b0, add_cin};
      for (int i = 1; i < 16; i++) pz[i] <= pz[i-1];
    end
  end
  assign add_ready = pv[lat-1] | force_rdy;
  assign add_z     = pz[lat-1][WIDTH-1:0];
  assign add_cout  = pz[lat-1][WIDTH];

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_cout(rsp_cout),
    .add_valid(add_valid), .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_ready(add_ready), .add_z(add_z), .add_cout(add_cout),
`ifdef ADDER_ARB_STATS_EN
    .stats_clr(stats_clr), .grant_cnt(grant_cnt),
`endif
    .err_orphan(err_orphan)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req_valid = '0;
    repeat (n) step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b1111;
    step();
    step();
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (add_valid !== 1'b0) begin errors++; $display("FAIL reset_add_valid: got %b expected 0", add_valid); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if ({rsp_z, add_x, add_y} !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", {rsp_z, add_x, add_y}); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_orphan); end
    req_valid = '0;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single();
    lat = 2;
    req_x = 32'h0000_00F1; req_y = 32'h0000_000C; req_cin = 4'b0000;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if ({add_valid, add_x, add_y, add_cin} !== {1'b1, 8'hF1, 8'h0C, 1'b0})
      begin errors++; $display("FAIL single_issue: got v=%b x=%h y=%h c=%b expected 1 f1 0c 0", add_valid, add_x, add_y, add_cin); end
    step();
    checks++; if (add_valid !== 1'b0 || add_x !== 8'hF1) begin errors++; $display("FAIL single_hold: got v=%b x=%h expected 0 f1", add_valid, add_x); end
    step();
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL single_early: got %b expected 0000", rsp_valid); end
    step();
    checks++; if ({rsp_valid, rsp_z, rsp_cout} !== {4'b0001, 8'hFD, 1'b0})
      begin errors++; $display("FAIL single_rsp: got v=%b z=%h c=%b expected 0001 fd 0", rsp_valid, rsp_z, rsp_cout); end
    step();
    checks++; if (rsp_valid !== 4'b0 || rsp_z !== 8'hFD) begin errors++; $display("FAIL single_rsp_hold: got v=%b z=%h expected 0000 fd", rsp_valid, rsp_z); end
  endtask

  task automatic test_carry();
    req_x = 32'h00FF_0000; req_y = 32'h00FF_0000; req_cin = 4'b0100;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL carry_grant: got %b expected 0100", req_ready); end
    step();
    req_valid = '0; req_cin = '0;
    repeat (3) step();
    checks++; if ({rsp_valid, rsp_z, rsp_cout} !== {4'b0100, 8'hFF, 1'b1})
      begin errors++; $display("FAIL carry_rsp: got v=%b z=%h c=%b expected 0100 ff 1", rsp_valid, rsp_z, rsp_cout); end
  endtask

  task automatic test_fairness();
    do_reset(1);
    lat = 1;
    req_x = '0; req_y = '0;
    req_valid = 4'b1111;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      exp_g = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", k, req_ready, exp_g); end
      if (k >= 3) begin
        exp_g = 4'b0001 << ((k - 3) % 4);
        checks++; if (rsp_valid !== exp_g) begin errors++; $display("FAIL fair_rsp[%0d]: got %b expected %b", k, rsp_valid, exp_g); end
      end
      step();
    end
`ifdef ADDER_ARB_STATS_EN
    checks++; if (grant_cnt !== 64'h0002_0002_0002_0002) begin errors++; $display("FAIL stats_fair: got %h expected 0002000200020002", grant_cnt); end
`endif
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_resume: got %b expected 0001", req_ready); end
    step();
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== ALT_G[k]) begin errors++; $display("FAIL fair_alt[%0d]: got %b expected %b", k, req_ready, ALT_G[k]); end
      step();
    end
    req_valid = '0;
    repeat (5) step();
  endtask

`ifdef ADDER_ARB_STATS_EN
  task automatic test_stats_clr();
    req_valid = 4'b0001;
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (grant_cnt[31:0] !== 32'h0) begin errors++; $display("FAIL stats_clr: got %h expected 00000000", grant_cnt[31:0]); end
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    #1;
    checks++; if (grant_cnt[31:16] !== 16'h1) begin errors++; $display("FAIL stats_inc: got %h expected 0001", grant_cnt[31:16]); end
    repeat (5) step();
  endtask
`endif

  task automatic test_full();
    do_reset(1);
    lat = 10;
    req_x = {8'h40, 8'h30, 8'h20, 8'h10};
    req_y = {8'h04, 8'h03, 8'h02, 8'h01};
    req_cin = '0;
    req_valid = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      #1;
      checks++; if (req_ready !== FULL_G[k]) begin errors++; $display("FAIL full_grant[%0d]: got %b expected %b", k, req_ready, FULL_G[k]); end
      checks++; if (rsp_valid !== FULL_R[k]) begin errors++; $display("FAIL full_rsp[%0d]: got %b expected %b", k, rsp_valid, FULL_R[k]); end
      if (FULL_R[k] != 4'b0) begin
        checks++; if (rsp_z !== FULL_Z[k]) begin errors++; $display("FAIL full_z[%0d]: got %h expected %h", k, rsp_z, FULL_Z[k]); end
      end
      step();
    end
    req_valid = '0;
    repeat (20) step();
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL full_no_orphan: got %b expected 0", err_orphan); end
  endtask

  task automatic test_orphan();
    force_rdy = 1'b1;
    step();
    force_rdy = 1'b0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b expected 1", err_orphan); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL orphan_rsp: got %b expected 0000", rsp_valid); end
    repeat (3) step();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
    do_reset(1);
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear: got %b expected 0", err_orphan); end
  endtask

  task automatic test_reset_mid();
    lat = 4;
    req_x = {8'h7E, 8'h00, 8'h00, 8'h00};
    req_y = {8'h05, 8'h00, 8'h00, 8'h00};
    req_valid = 4'b0111;
    repeat (3) step();
    req_valid = 4'b1000;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready); end
    step();
    step();
    checks++; if ({add_valid, rsp_valid, err_orphan, rsp_z, add_x} !== 22'h0)
      begin errors++; $display("FAIL mid_outputs: got %h expected 000000", {add_valid, rsp_valid, err_orphan, rsp_z, add_x}); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_grant: got %b expected 1000", req_ready); end
    step();
    req_valid = '0;
    for (int k = 2; k < 6; k++) begin
      step();
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_quiet[%0d]: got %b expected 0000", k, rsp_valid); end
    end
    step();
    checks++; if ({rsp_valid, rsp_z, rsp_cout} !== {4'b1000, 8'h83, 1'b0})
      begin errors++; $display("FAIL mid_rsp: got v=%b z=%h c=%b expected 1000 83 0", rsp_valid, rsp_z, rsp_cout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_fairness();
`ifdef ADDER_ARB_STATS_EN
    test_stats_clr();
`endif
    test_full();
    test_orphan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one pipelined adder (the 8-bit Brent-Kung adder or any same-interface adder) among NUM_REQ requesters.
- Grants at most one operation per cycle and registers operands into the adder.
- Tracks the owner of each in-flight operation in a tag FIFO and routes each result back to its originating requester.
- Handles any adder latency, including variable latency; results must return in issue order.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width.
- MAX_OUT, 4, maximum in-flight operations, equal to the tag FIFO depth (power of 2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when req_valid[i]&req_ready[i].
- req_x  in  NUM_REQ*WIDTH  packed X operands, requester i at bits [i*WIDTH +: WIDTH].
- req_y  in  NUM_REQ*WIDTH  packed Y operands.
- req_cin  in  NUM_REQ  per-requester carry-in.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe to the owner.
- rsp_z  out  WIDTH  result sum, valid with rsp_valid.
- rsp_cout  out  1  result carry-out.
- add_valid  out  1  to adder iValid.
- add_x  out  WIDTH  to adder iX.
- add_y  out  WIDTH  to adder iY.
- add_cin  out  1  to adder iCarryIn.
- add_ready  in  1  adder oReady (result valid).
- add_z  in  WIDTH  adder oZ.
- add_cout  in  1  adder oCarryOut.
- err_orphan  out  1  sticky: adder produced a result with no outstanding tag.

Behaviour:
- Reset (sync, active-high):
  - All outputs 0.
  - RR pointer = 0; tag FIFO empty (count = 0); err_orphan = 0.
  - In-flight tags are discarded; the adder must be reset in the same cycle.
- Grant (combinational from registered state and current req_valid):
  - Candidate = first i with req_valid[i], searching ptr, ptr+1, … modulo NUM_REQ.
  - issue_ok = (count < MAX_OUT) | pop_this_cycle.
  - req_ready = onehot(candidate) if any request and issue_ok, else 0.
  - req_ready never asserts for a requester with req_valid low.
- On a handshake at cycle t:
  - Push the candidate index into the tag FIFO.
  - ptr ← candidate+1 mod NUM_REQ. ptr is unchanged on cycles with no grant.
  - add_x/add_y/add_cin are registered from that requester; add_valid = 1 in cycle t+1 only.
- With no handshake, add_valid = 0 the next cycle and add_x/add_y/add_cin hold their previous values.
- Back-to-back issues are allowed, one per cycle.
- Result path, when add_ready = 1 in cycle r:
  - Pop the head tag.
  - In cycle r+1: rsp_valid = onehot(tag), rsp_z = add_z, rsp_cout = add_cout.
  - Otherwise rsp_valid = 0; rsp_z/rsp_cout hold their previous values.
  - Responses have no backpressure; requesters must always accept them.
- Occupancy and boundaries:
  - count changes +1 on push only, -1 on pop only, unchanged on push & pop together.
  - Full (count = MAX_OUT) with a pop in the same cycle: a grant is allowed and count stays MAX_OUT.
  - add_ready with count = 0: set err_orphan (sticky until reset), discard the result, no rsp_valid, count stays 0.
  - FIFO read/write pointers wrap modulo MAX_OUT.
- Latency:
  - Request handshake → add_valid: 1 cycle.
  - add_ready → rsp_valid: 1 cycle.
  - Total = adder latency + 2.

Optional Feature:
- ADDER_ARB_STATS_EN
- Defined:
  - Adds output grant_cnt (NUM_REQ*16): per-requester 16-bit counters, incremented on each handshake and saturating at 16'hFFFF.
  - Adds input stats_clr: synchronous clear to 0, with priority over increment in the same cycle.
  - reset also clears the counters.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Bench uses an adder model with latency L.
- Single op, L=2: requester 0 sends x=F1, y=0C, cin=0 → add_valid 1 cycle later; rsp_valid=0001, rsp_z=FD, rsp_cout=0, 4 cycles after the handshake.
- Carry routing: requester 2 sends FF+FF, cin=1 → rsp_valid=0100, rsp_z=FF, rsp_cout=1.
- Fairness: all 4 requesters held valid for 8 cycles, FIFO never full (L=1) → grant order 0,1,2,3,0,1,2,3; ptr resumes correctly after a gap. Requesters 1 and 3 only → 1,3,1,3.
- Full/simultaneous, MAX_OUT=4, L=10, continuous requests:
  - 4 grants, then req_ready=0 until the first add_ready.
  - In that cycle one new grant is issued and count stays 4.
  - Results return tagged in issue order.
- Orphan: force add_ready=1 with empty FIFO → err_orphan=1 next cycle and stays set; no rsp_valid. reset → err_orphan=0.
- Reset mid-op: 3 ops in flight, then reset for 2 cycles → all outputs 0, ptr=0. A new request from requester 3 completes normally with rsp_valid=1000.
- ADDER_ARB_STATS_EN:
  - After the fairness test, grant_cnt=2 for each requester.
  - stats_clr asserted in the same cycle as a grant → counter reads 0.
